tcm_arbiter: RTL and testbench
==============================

# tcm_arbiter

Round-robin arbiter that shares one port of the dual-port TCM scratchpad RAM among several requesting masters, e.g. the four cores' data-side load/store units. It sits directly upstream of the RAM port. It accepts held-request, ready-terminated transactions from N masters and issues exactly one registered read or write command at a time. It routes the RAM's one-cycle-later ready/data response back to the granted master.

## Interface
Parameters:
- N_MASTERS, 4, number of requesting masters (2..8)
- DATA_WIDTH, 32, data word width (multiple of 8)
- N_ENTRIES, 1024, RAM depth in words
- ADDRW, $clog2(N_ENTRIES), word-address width

Ports:
- clk_i  in  1  single clock for arbiter and attached RAM port
- rstn_i  in  1  reset, synchronous, active-low
- m_req_i  in  N_MASTERS  per-master request, held high until that master's m_ready_o
- m_we_i  in  N_MASTERS  per-master write enable (1 = write)
- m_be_i  in  N_MASTERS*DATA_WIDTH/8  byte enables, master k at slice k
- m_addr_i  in  N_MASTERS*ADDRW  word addresses, master k at slice k
- m_data_i  in  N_MASTERS*DATA_WIDTH  write data, master k at slice k
- m_ready_o  out  N_MASTERS  one-cycle completion pulse to the granted master
- m_data_o  out  DATA_WIDTH  read data, broadcast; valid only with a m_ready_o bit
- mem_en_o  out  1  RAM port enable
- mem_we_o  out  1  RAM port write enable
- mem_be_o  out  DATA_WIDTH/8  RAM byte enables
- mem_addr_o  out  ADDRW  RAM word address
- mem_data_o  out  DATA_WIDTH  RAM write data
- mem_data_i  in  DATA_WIDTH  RAM read data
- mem_ready_i  in  1  RAM ready; high the cycle after an enabled access

## Operation
- FSM with three states:
  - IDLE: if any m_req_i is set, grant the first requester at or after pointer `prio`, searching cyclically. Latch that master's we/be/addr/data into the mem_* registers, set grant index `gnt`, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mem_en_o = 1 for exactly this cycle, then go to WAIT.
  - WAIT: mem_en_o = 0. When mem_ready_i = 1, then m_ready_o[gnt] = 1, m_data_o = mem_data_i, prio <= (gnt+1) mod N_MASTERS, and go to IDLE. Otherwise stay in WAIT.
- Writes complete identically to reads: ready is returned. m_data_o is don't-care for writes, but is still driven from mem_data_i.
- mem_we_o/be/addr/data hold their latched values until the next grant. mem_we_o is qualified by mem_en_o only.
- Master contract: deassert m_req_i on the cycle after m_ready_o. Changing we/be/addr/data while requesting and not yet granted is allowed; the values sampled in IDLE are used.
- Requests arriving during ISSUE or WAIT wait for the next IDLE. No request is dropped.
- mem_ready_i outside WAIT is ignored, and no m_ready_o is raised.
- At most one m_ready_o bit is high in any cycle.

## Timing
- Reset values:
  - state = IDLE, prio = 0, gnt = 0
  - mem_en_o = 0, mem_we_o = 0, mem_be_o = 0, mem_addr_o = 0, mem_data_o = 0
  - m_ready_o = 0
  - m_data_o follows mem_data_i (combinational)
- Latency: request seen in IDLE at cycle t → mem_en_o high in cycle t+1 → mem_ready_i and m_ready_o high in cycle t+2. Minimum 3 cycles per access, with back-to-back grants every 3 cycles.
- m_ready_o and m_data_o are combinational from mem_ready_i and state. All mem_* outputs are registered.
- Reset asserted mid-transaction (ISSUE or WAIT): return to IDLE next edge. A late mem_ready_i is ignored and no m_ready_o is produced; the master re-requests.
- Simultaneous requests: strict rotation. With all N requesting continuously, each master is served once every 3·N cycles.

## Structure
- Shared package tcm_pkg: state enum (IDLE, ISSUE, WAIT) and a localparam for byte-enable width.
- One sub-module: rr_pick, a combinational cyclic priority encoder. Inputs are req vector and prio; outputs are a valid flag and an index. It is reusable for other shared ports.

## Test plan
- Single read: after reset, master 2 requests addr 0x010, RAM holds 0xDEADBEEF → mem_en_o at t+1 with addr 0x010, m_ready_o = 0100 and m_data_o = 0xDEADBEEF at t+2, prio = 3.
- Byte write: master 0 writes 0x000000AB, be = 0001 to addr 5, then reads addr 5 → the read returns the old upper bytes with low byte 0xAB.
- Contention: all 4 masters request from the same cycle with prio = 0 → grants in order 0, 1, 2, 3, 0 spaced 3 cycles apart. Never two m_ready_o bits high together.
- Late arrival: master 1 requests during master 3's WAIT → master 1 is granted in the following IDLE, its ready 3 cycles later.
- Reset mid-op: rstn_i low during WAIT with mem_ready_i high one cycle later → m_ready_o stays 0, state IDLE, prio = 0, mem_en_o = 0.
- Stray ready: mem_ready_i pulsed while IDLE with no requests → no m_ready_o, state unchanged.

Source files
------------

// File: rtl/tcm_pkg.sv
// Shared types for the TCM port arbiter: FSM state encoding and byte-lane width.
package tcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority encoder: first set req bit at or after prio_i.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] prio_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [N-1:0] req_rot;
  logic [IW:0]  sum;

  always_comb begin
    // Rotate so bit 0 is the master at prio_i; the lowest set bit then wins.
    req_rot = (req_i >> prio_i) | (req_i << (N_W - {1'b0, prio_i}));
    valid_o = 1'b0;
    sum     = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (req_rot[i]) begin
        valid_o = 1'b1;
        sum     = {1'b0, prio_i} + (IW+1)'(i);
      end
    end
    if (sum >= N_W) sum = sum - N_W;
    idx_o = sum[IW-1:0];
  end

endmodule

// File: rtl/tcm_arbiter.sv
// Round-robin arbiter sharing one TCM RAM port among N masters; one access at a time,
// registered command, RAM response routed combinationally back to the granted master.
module tcm_arbiter
  import tcm_pkg::*;
#(
  parameter int N_MASTERS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int N_ENTRIES  = 1024,
  parameter int ADDRW      = $clog2(N_ENTRIES)
) (
  input  logic                                     clk_i,
  input  logic                                     rstn_i,
  input  logic [N_MASTERS-1:0]                     m_req_i,
  input  logic [N_MASTERS-1:0]                     m_we_i,
  input  logic [N_MASTERS*(DATA_WIDTH/BYTE_W)-1:0] m_be_i,
  input  logic [N_MASTERS*ADDRW-1:0]               m_addr_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]          m_data_i,
  output logic [N_MASTERS-1:0]                     m_ready_o,
  output logic [DATA_WIDTH-1:0]                    m_data_o,
  output logic                                     mem_en_o,
  output logic                                     mem_we_o,
  output logic [DATA_WIDTH/BYTE_W-1:0]             mem_be_o,
  output logic [ADDRW-1:0]                         mem_addr_o,
  output logic [DATA_WIDTH-1:0]                    mem_data_o,
  input  logic [DATA_WIDTH-1:0]                    mem_data_i,
  input  logic                                     mem_ready_i
);

  localparam int BE_W = DATA_WIDTH / BYTE_W;
  localparam int GW   = $clog2(N_MASTERS);

  state_e                state_q;
  logic [GW-1:0]         prio_q, prio_d, gnt_q;
  logic                  pick_valid;
  logic [GW-1:0]         pick_idx;
  logic                  done;
  logic                  mem_en_q, mem_we_q;
  logic [BE_W-1:0]       mem_be_q;
  logic [ADDRW-1:0]      mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;

  logic [BE_W-1:0]       be_a   [N_MASTERS];
  logic [ADDRW-1:0]      addr_a [N_MASTERS];
  logic [DATA_WIDTH-1:0] data_a [N_MASTERS];

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_split
    assign be_a[k]   = m_be_i[k*BE_W +: BE_W];
    assign addr_a[k] = m_addr_i[k*ADDRW +: ADDRW];
    assign data_a[k] = m_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.N(N_MASTERS), .IW(GW)) u_pick (
    .req_i   (m_req_i),
    .prio_i  (prio_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    if (gnt_q == GW'(N_MASTERS-1)) prio_d = '0;
    else                           prio_d = gnt_q + 1'b1;
  end

  // A response landing while reset is applied is dropped; the master re-requests.
  assign done = (state_q == ST_WAIT) && mem_ready_i && rstn_i;

  always_comb begin
    m_ready_o = '0;
    if (done) m_ready_o[gnt_q] = 1'b1;
  end

  assign m_data_o   = mem_data_i;
  assign mem_en_o   = mem_en_q;
  assign mem_we_o   = mem_we_q;
  assign mem_be_o   = mem_be_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      prio_q     <= '0;
      gnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_q      <= pick_idx;
            mem_en_q   <= 1'b1;
            mem_we_q   <= m_we_i[pick_idx];
            mem_be_q   <= be_a[pick_idx];
            mem_addr_q <= addr_a[pick_idx];
            mem_data_q <= data_a[pick_idx];
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (mem_ready_i) begin
            prio_q  <= prio_d;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_arbiter.sv
// Bench for tcm_arbiter: random held-request masters, a behavioural RAM, a transaction-level
// reference model feeding expected queues, and a negedge monitor that pops and compares.
module tb_tcm_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int NE    = 1024;
  localparam int AW    = 10;
  localparam int BW    = DW / 8;
  localparam int ISS_W = 32 + 1 + BW + AW + DW;  // cycle, we, be, addr, data
  localparam int CMP_W = 32 + N + 1 + DW;        // cycle, ready mask, is_read, data

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rstn_i = 1'b0;
  logic [N-1:0]    m_req_i = '0;
  logic [N-1:0]    m_we_i = '0;
  logic [N*BW-1:0] m_be_i = '0;
  logic [N*AW-1:0] m_addr_i = '0;
  logic [N*DW-1:0] m_data_i = '0;
  logic [N-1:0]    m_ready_o;
  logic [DW-1:0]   m_data_o;
  logic            mem_en_o, mem_we_o;
  logic [BW-1:0]   mem_be_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_data_o;
  logic [DW-1:0]   mem_data_i = '0;
  logic            mem_ready_i = 1'b0;

  always #5 clk = ~clk;

  tcm_arbiter #(.N_MASTERS(N), .DATA_WIDTH(DW), .N_ENTRIES(NE)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .m_req_i     (m_req_i),
    .m_we_i      (m_we_i),
    .m_be_i      (m_be_i),
    .m_addr_i    (m_addr_i),
    .m_data_i    (m_data_i),
    .m_ready_o   (m_ready_o),
    .m_data_o    (m_data_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ready_i (mem_ready_i)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  logic [ISS_W-1:0] iss_q[$];
  logic [CMP_W-1:0] cmp_q[$];
  logic [ISS_W-1:0] ie;
  logic [CMP_W-1:0] ce;

  // master stimulus
  logic [N-1:0]  req = '0;
  logic [N-1:0]  start_req = '0;
  logic [N-1:0]  drop_mask = '0;
  logic          we_a   [N];
  logic [BW-1:0] be_a   [N];
  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];
  int            rand_pct = 0;
  int            amax = 15;

  // behavioural RAM and reference memory
  logic [DW-1:0] ram     [NE];
  logic [DW-1:0] ref_mem [NE];
  logic [DW-1:0] ram_rd = '0;
  int            ram_cnt = -1;
  int            lat_lo = 0;
  int            lat_hi = 0;
  bit            stray = 1'b0;
  bit            rst_req = 1'b1;

  // reference model: one outstanding access, rotating priority
  bit            busy = 1'b0;
  int            m_prio = 0;
  int            m_gnt = 0;
  int            issue_cyc = 0;
  bit            m_read = 1'b0;
  logic [DW-1:0] m_exp = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic rand_attrs(input int m);
    we_a[m]   = 1'($urandom_range(1, 0));
    be_a[m]   = BW'($urandom_range(15, 1));
    addr_a[m] = AW'($urandom_range(amax, 0));
    data_a[m] = $urandom;
  endtask

  task automatic request(input int m, input logic we, input logic [BW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    we_a[m] = we; be_a[m] = be; addr_a[m] = addr; data_a[m] = data;
    start_req[m] = 1'b1;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [N-1:0] dropped;
    bit           found;
    int           c;
    @(posedge clk);
    #1;
    cyc++;
    dropped = drop_mask;
    req = req & ~drop_mask;
    drop_mask = '0;
    req = req | start_req;
    start_req = '0;
    for (int m = 0; m < N; m++) begin
      if (!req[m] && !dropped[m] && rand_pct > 0 && $urandom_range(99, 0) < rand_pct) begin
        rand_attrs(m);
        req[m] = 1'b1;
      end else if (req[m] && !(busy && m_gnt == m) && rand_pct > 0 && $urandom_range(3, 0) == 0) begin
        rand_attrs(m);
      end
    end
    rstn_i  = !rst_req;
    m_req_i = req;
    for (int m = 0; m < N; m++) begin
      m_we_i[m]            = we_a[m];
      m_be_i[m*BW +: BW]   = be_a[m];
      m_addr_i[m*AW +: AW] = addr_a[m];
      m_data_i[m*DW +: DW] = data_a[m];
    end

    // RAM: respond lat cycles after the enabled cycle, then accept a new command
    mem_ready_i = 1'b0;
    if (ram_cnt == 0) begin
      mem_ready_i = 1'b1;
      mem_data_i  = ram_rd;
    end
    if (ram_cnt >= 0) ram_cnt--;
    if (stray) begin
      mem_ready_i = 1'b1;
      mem_data_i  = $urandom;
      stray       = 1'b0;
    end
    if (mem_en_o) begin
      ram_rd = ram[mem_addr_o];
      if (mem_we_o)
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] = mem_data_o[8*b +: 8];
      ram_cnt = $urandom_range(lat_hi, lat_lo);
    end

    // reference model
    if (!rstn_i) begin
      if (busy) drop_mask[m_gnt] = 1'b1;
      busy   = 1'b0;
      m_prio = 0;
    end else if (busy && cyc > issue_cyc && mem_ready_i) begin
      cmp_q.push_back({32'(cyc), N'(1 << m_gnt), m_read, m_exp});
      drop_mask[m_gnt] = 1'b1;
      m_prio = (m_gnt + 1) % N;
      busy   = 1'b0;
    end else if (!busy && req != '0) begin
      found = 1'b0;
      for (int o = 0; o < N; o++) begin
        c = (m_prio + o) % N;
        if (!found && req[c]) begin
          found = 1'b1;
          m_gnt = c;
        end
      end
      iss_q.push_back({32'(cyc + 1), we_a[m_gnt], be_a[m_gnt], addr_a[m_gnt], data_a[m_gnt]});
      m_read = !we_a[m_gnt];
      m_exp  = ref_mem[addr_a[m_gnt]];
      if (we_a[m_gnt])
        for (int b = 0; b < BW; b++)
          if (be_a[m_gnt][b]) ref_mem[addr_a[m_gnt]][8*b +: 8] = data_a[m_gnt][8*b +: 8];
      busy      = 1'b1;
      issue_cyc = cyc + 1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || req != '0 || start_req != '0 || ram_cnt >= 0) && n < 300) begin
      step();
      n++;
    end
    check("drain_within_budget", 128'(n < 300), 128'(1));
  endtask

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    repeat (n) step();
    rst_req = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_en_o) begin
        if (iss_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_issue @cyc %0d: got addr %0h we %0b, none expected",
                   cyc, mem_addr_o, mem_we_o);
        end else begin
          ie = iss_q.pop_front();
          check("issue_cmd", 128'({32'(cyc), mem_we_o, mem_be_o, mem_addr_o, mem_data_o}), 128'(ie));
        end
      end
      if (m_ready_o != '0) begin
        check("ready_onehot", 128'($onehot0(m_ready_o)), 128'(1));
        if (cmp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ready @cyc %0d: got %b, none expected", cyc, m_ready_o);
        end else begin
          ce = cmp_q.pop_front();
          check("ready_cyc_mask", 128'({32'(cyc), m_ready_o}), 128'(ce[CMP_W-1 -: 32+N]));
          if (ce[DW]) check("read_data", 128'(m_data_o), 128'(ce[DW-1:0]));
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < NE; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    for (int m = 0; m < N; m++) begin
      we_a[m] = 1'b0; be_a[m] = '0; addr_a[m] = '0; data_a[m] = '0;
    end

    do_reset(3);
    check("rst_mem_en", 128'(mem_en_o), 128'(0));
    check("rst_mem_we", 128'(mem_we_o), 128'(0));
    check("rst_mem_be", 128'(mem_be_o), 128'(0));
    check("rst_mem_addr", 128'(mem_addr_o), 128'(0));
    check("rst_mem_data", 128'(mem_data_o), 128'(0));
    check("rst_m_ready", 128'(m_ready_o), 128'(0));
    mon_en = 1'b1;

    // single read by master 2
    ram[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    request(2, 1'b0, 4'hF, 10'h010, 32'h0);
    drain();
    check("prio_after_single", 128'(dut.prio_q), 128'(3));

    // byte write then read back
    ram[5] = 32'h12345678;
    ref_mem[5] = 32'h12345678;
    request(0, 1'b1, 4'b0001, 10'd5, 32'h000000AB);
    drain();
    request(0, 1'b0, 4'hF, 10'd5, 32'h0);
    drain();
    check("byte_merge_ref", 128'(ram[5]), 128'(32'h123456AB));

    // contention from prio 0: all masters request together and keep re-requesting
    do_reset(2);
    for (int m = 0; m < N; m++) request(m, 1'b0, 4'hF, AW'(m + 32), 32'h0);
    rand_pct = 100;
    repeat (40) step();
    rand_pct = 0;
    drain();

    // late arrival: master 1 asks while master 3 waits on the RAM
    request(3, 1'b0, 4'hF, 10'd40, 32'h0);
    step();
    step();
    request(1, 1'b1, 4'hC, 10'd41, $urandom);
    drain();

    // randomized traffic with variable RAM latency and colliding addresses
    lat_lo = 0; lat_hi = 2; amax = 15;
    rand_pct = 25;
    repeat (500) step();
    rand_pct = 0;
    drain();
    lat_hi = 0;

    // stray ready while idle
    stray = 1'b1;
    step();
    #1;
    check("stray_no_ready", 128'(m_ready_o), 128'(0));
    step();
    check("stray_state_idle", 128'(dut.state_q), 128'(tcm_pkg::ST_IDLE));

    // reset during WAIT; RAM answers late, in IDLE
    lat_lo = 2; lat_hi = 2;
    request(1, 1'b0, 4'hF, 10'd7, 32'h0);
    step();
    step();
    step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    #1;
    check("late_ready_mem_ready", 128'(mem_ready_i), 128'(1));
    check("late_ready_no_m_ready", 128'(m_ready_o), 128'(0));
    check("rst_mid_state_idle", 128'(dut.state_q), 128'(tcm_pkg::ST_IDLE));
    check("rst_mid_prio", 128'(dut.prio_q), 128'(0));
    check("rst_mid_mem_en", 128'(mem_en_o), 128'(0));
    lat_lo = 0; lat_hi = 0;
    drain();

    // master 1 re-requests after the aborted access
    request(1, 1'b0, 4'hF, 10'd7, 32'h0);
    drain();
    repeat (3) step();
    check("iss_q_empty", 128'(iss_q.size()), 128'(0));
    check("cmp_q_empty", 128'(cmp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
